// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding
// requests to instruction memory and buffers returned words in a prefetch FIFO.
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [63:0]   fifo_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [31:0]   fpc;
  logic [31:0]   fpc_base;
  logic [63:0]   head;
  logic          discard;
  logic          pop;
  logic          push;
  logic          flush;
  logic          issue;

  always_comb begin
    instr_valid = (count != '0);
    head        = fifo_mem[rd_ptr];
    Instr       = instr_valid ? head[31:0]  : '0;
    PC          = instr_valid ? head[63:32] : '0;
    PCPlus8     = PC + 32'd8;
  end

  // A redirect overrides the fetch pointer in the same edge, so a request
  // issued alongside a flush already targets the branch destination.
  always_comb begin
    pop        = instr_valid & instr_ready;
    flush      = pop & PCSrc;
    push       = imem_ack & imem_req & ~discard & ~flush;
    count_next = flush ? '0 : count + CW'(push) - CW'(pop);
    fpc_base   = flush ? (BranchTarget & 32'hFFFF_FFFC) : fpc;
    issue      = (~imem_req | imem_ack) & (count_next < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_req  <= 1'b0;
      imem_addr <= '0;
      fpc       <= RESET_PC;
      discard   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      if (issue) begin
        imem_req  <= 1'b1;
        imem_addr <= fpc_base;
        fpc       <= fpc_base + 32'd4;
      end else begin
        if (imem_ack) imem_req <= 1'b0;
        fpc <= fpc_base;
      end

      // An in-flight request that survives a flush returns stale data.
      if (flush & imem_req & ~imem_ack) discard <= 1'b1;
      else if (imem_req & imem_ack)     discard <= 1'b0;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {imem_addr, imem_rdata};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed latency/stall/redirect/reset scenarios plus
// randomized traffic checked against a transaction-level fetch model.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] RESET_W  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, instr_valid, instr_ready, PCSrc;
  logic [31:0] imem_addr, imem_rdata, Instr, PC, PCPlus8, BranchTarget;

  logic        w_rst, w_req, w_ack, w_valid, w_ready;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc8;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Instr(Instr), .PC(PC), .PCPlus8(PCPlus8),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget)
  );

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_W)) u_wrap (
    .clk(clk), .reset(w_rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .instr_valid(w_valid),
    .instr_ready(w_ready), .Instr(w_instr), .PC(w_pc), .PCPlus8(w_pc8),
    .PCSrc(1'b0), .BranchTarget(32'h0)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb [$];
  logic        stale;
  logic [31:0] exp_fetch, prev_addr, last_new;
  logic        prev_req, prev_ack;
  int          wcnt, cur_ws, ws_mode, n_new, n_pop;
  bit          spur_en, force_spur;
  int          nv, n0, p0, dcnt;
  logic [31:0] nreq, npc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic post_check();
    check("valid", instr_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      check("head_pc", PC, sb[0]);
      check("head_instr", Instr, word_of(sb[0]));
      check("head_pc8", PCPlus8, sb[0] + 32'd8);
    end else begin
      check("empty_pc", PC, 32'h0);
      check("empty_instr", Instr, 32'h0);
      check("empty_pc8", PCPlus8, 32'h8);
    end
    check("occupancy", sb.size() <= DEPTH, 1);
    if (prev_req && !prev_ack) begin
      check("hold_req", imem_req, 1);
      check("hold_addr", imem_addr, prev_addr);
    end else begin
      check("issue", imem_req, sb.size() < DEPTH);
      if (imem_req) begin
        check("fetch_addr", imem_addr, exp_fetch);
        last_new  = imem_addr;
        exp_fetch = imem_addr + 32'd4;
        n_new++;
        wcnt   = 0;
        cur_ws = (ws_mode < 0) ? int'($urandom_range(0, 3)) : ws_mode;
      end
    end
  endtask

  // Called just after a negedge with the downstream inputs already set.
  task automatic tick();
    logic pop, flush, ackev;
    if (imem_req) begin
      imem_ack = (wcnt >= cur_ws);
      wcnt++;
    end else begin
      imem_ack = force_spur || (spur_en && $urandom_range(0, 3) == 0);
    end
    force_spur = 0;
    imem_rdata = imem_ack ? word_of(imem_addr) : $urandom();
    pop   = instr_valid & instr_ready;
    flush = pop & PCSrc;
    ackev = imem_ack & imem_req;
    if (pop && sb.size() != 0) begin
      void'(sb.pop_front());
      n_pop++;
    end
    if (flush) begin
      sb.delete();
      stale     = imem_req & ~imem_ack;
      exp_fetch = BranchTarget & 32'hFFFF_FFFC;
    end
    if (ackev) begin
      if (stale)       stale = 0;
      else if (!flush) sb.push_back(imem_addr);
    end
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
    @(negedge clk);
    post_check();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    PCSrc = 1'b0;
    sb.delete();
    stale = 0;
    prev_req = 0;
    prev_ack = 0;
    exp_fetch = RESET_PC;
    wcnt = 0;
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", Instr, 32'h0);
    check("rst_pc", PC, 32'h0);
    check("rst_pc8", PCPlus8, 32'h8);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; w_rst = 1'b0; w_ack = 1'b0; w_ready = 1'b0; w_rdata = '0;
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0; PCSrc = 1'b0;
    BranchTarget = '0; ws_mode = 0; spur_en = 0; force_spur = 0;
    n_new = 0; n_pop = 0; cur_ws = 0;
    @(negedge clk);

    // Zero-wait memory: latency and one instruction per cycle.
    do_reset();
    instr_ready = 1'b1;
    tick();
    check("first_req", imem_req, 1);
    check("first_valid_early", instr_valid, 0);
    tick();
    check("first_valid", instr_valid, 1);
    check("first_pc", PC, 32'h0);
    check("first_pc8", PCPlus8, 32'h8);
    check("second_addr", imem_addr, 32'h4);
    nv = 0;
    repeat (8) begin tick(); nv += int'(instr_valid); end
    check("throughput", nv, 8);

    // Stall fills exactly DEPTH entries, then drains without a gap.
    do_reset();
    instr_ready = 1'b0;
    repeat (10) tick();
    check("stall_req", imem_req, 0);
    check("stall_pc", PC, 32'h0);
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("drain_valid", instr_valid, 1);
      check("drain_pc", PC, 32'(k * 4));
      tick();
    end

    // Three wait states: one instruction every four cycles.
    do_reset();
    ws_mode = 3;
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    check("ws_first", instr_valid, 1);
    nv = 0;
    repeat (16) begin tick(); nv += int'(instr_valid); end
    check("ws_rate", nv, 4);

    // Redirect while the next fetch is still waiting on memory.
    ws_mode = 0;
    do_reset();
    repeat (10) tick();
    ws_mode = 3;
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && !(instr_valid && PC == 32'h8); i++) tick();
    check("redir_head", PC, 32'h8);
    check("redir_outstanding", imem_req, 1);
    PCSrc = 1'b1;
    BranchTarget = 32'h0000_0103;
    tick();
    PCSrc = 1'b0;
    BranchTarget = 32'h0000_0040;
    n0 = n_new;
    for (int i = 0; i < 20 && n_new == n0; i++) tick();
    check("redir_fetch", last_new, 32'h100);
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    check("redir_pc", PC, 32'h100);

    // Asynchronous reset mid-wait, late ack right after release.
    for (int i = 0; i < 20 && !(imem_req && wcnt == 1); i++) tick();
    check("midreq_wait", imem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("async_req", imem_req, 0);
    check("async_addr", imem_addr, 32'h0);
    check("async_valid", instr_valid, 0);
    do_reset();
    force_spur = 1;
    instr_ready = 1'b1;
    tick();
    check("late_ack_valid", instr_valid, 0);
    check("late_ack_addr", imem_addr, RESET_PC);

    // Fetch pointer and PCPlus8 wrap at 2^32.
    w_ready = 1'b1;
    w_rst = 1'b1;
    nreq = RESET_W;
    npc = RESET_W;
    dcnt = 0;
    repeat (6) begin
      w_ack = w_req;
      w_rdata = word_of(w_addr);
      @(negedge clk);
      if (w_req) begin
        check("wrap_fetch", w_addr, nreq);
        nreq = nreq + 32'd4;
      end
      if (w_valid) begin
        check("wrap_pc", w_pc, npc);
        check("wrap_pc8", w_pc8, npc + 32'd8);
        check("wrap_instr", w_instr, word_of(npc));
        npc = npc + 32'd4;
        dcnt++;
      end
    end
    check("wrap_count", dcnt, 5);

    // Randomized traffic: wait states, stalls, redirects, stray acks.
    do_reset();
    ws_mode = -1;
    spur_en = 1;
    p0 = n_pop;
    repeat (3000) begin
      instr_ready  = ($urandom_range(0, 3) != 0);
      PCSrc        = ($urandom_range(0, 4) == 0);
      BranchTarget = $urandom();
      tick();
    end
    check("random_progress", (n_pop - p0) > 300, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
